sprite_rom_sched: RTL and testbench

Round-robin scheduler that shares the single 8x8 one-bit sprite ROM between several row requesters, such as the dino, obstacle and score renderers. It drives the ROM's 6-bit `{row, col}` counter for eight consecutive cycles per grant and assembles the returned colour bits into an 8-bit row word. It then hands the word back to the granted requester with a one-cycle acknowledge. It sits between the per-object renderers and the sprite ROM instance.

---
 rtl/sprite_rom_sched_if.sv | 34 +++
 rtl/sprite_rom_sched.sv | 148 ++++++++++++++
 tb/tb_sprite_rom_sched.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_rom_sched_if.sv
// Bundle between the per-object row renderers, the sprite ROM and sprite_rom_sched.
// i_mirror exists only when SPRITE_SCHED_MIRROR_EN is defined.
interface sprite_rom_sched_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   i_req;
    logic [3*NUM_REQ-1:0] i_row;
    logic [5:0]           o_rom_counter;
    logic                 i_rom_color;
    logic [NUM_REQ-1:0]   o_ack;
    logic [7:0]           o_row_data;
    logic                 o_busy;
`ifdef SPRITE_SCHED_MIRROR_EN
    logic [NUM_REQ-1:0]   i_mirror;

    modport slave (
        input  i_req, i_row, i_rom_color, i_mirror,
        output o_rom_counter, o_ack, o_row_data, o_busy
    );
    modport master (
        output i_req, i_row, i_rom_color, i_mirror,
        input  o_rom_counter, o_ack, o_row_data, o_busy
    );
`else
    modport slave (
        input  i_req, i_row, i_rom_color,
        output o_rom_counter, o_ack, o_row_data, o_busy
    );
    modport master (
        output i_req, i_row, i_rom_color,
        input  o_rom_counter, o_ack, o_row_data, o_busy
    );
`endif
endinterface

// File: rtl/sprite_rom_sched.sv
// Round-robin sharer of the 8x8 one-bit sprite ROM: grant, walk 8 columns, ack one row word.
// Latency: ack visible 9 cycles after the grant edge, one row per 10 cycles; no backpressure (level requests).
// Optional horizontal mirroring is built when SPRITE_SCHED_MIRROR_EN is defined.
module sprite_rom_sched #(
    parameter int NUM_REQ = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    sprite_rom_sched_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic               mirror_q, mirror_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         data_q, data_d;
    logic [5:0]         rom_counter_q, rom_counter_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         row_data_q, row_data_d;
    logic               busy_q, busy_d;

    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [2:0]         grant_row;
    logic               grant_mir;
    int                 cand;

    // col_q counts samples 0..7; the ROM column is that count, reversed when mirroring.
    function automatic logic [2:0] rom_col(input logic [2:0] step, input logic mir);
        return mir ? (3'd7 - step) : step;
    endfunction

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_vld && bus.i_req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    assign grant_row = bus.i_row[3*int'(grant_idx) +: 3];

`ifdef SPRITE_SCHED_MIRROR_EN
    assign grant_mir = bus.i_mirror[grant_idx];
`else
    assign grant_mir = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        mirror_d      = mirror_q;
        win_d         = win_q;
        rr_ptr_d      = rr_ptr_q;
        data_d        = data_q;
        rom_counter_d = rom_counter_q;
        ack_d         = '0;
        row_data_d    = '0;
        busy_d        = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    win_d         = grant_idx;
                    row_d         = grant_row;
                    mirror_d      = grant_mir;
                    col_d         = 3'd0;
                    rom_counter_d = {grant_row, rom_col(3'd0, grant_mir)};
                    state_d       = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // The ROM answers combinationally for the address already on the bus.
                data_d[col_q] = bus.i_rom_color;
                col_d         = col_q + 3'd1;
                if (col_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    rom_counter_d = {row_q, rom_col(col_q + 3'd1, mirror_q)};
                end
            end
            ST_DONE: begin
                ack_d      = NUM_REQ'(1) << win_q;
                row_data_d = data_q;
                rr_ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : (win_q + 1'b1);
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            mirror_q      <= 1'b0;
            win_q         <= '0;
            rr_ptr_q      <= '0;
            data_q        <= '0;
            rom_counter_q <= '0;
            ack_q         <= '0;
            row_data_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            mirror_q      <= mirror_d;
            win_q         <= win_d;
            rr_ptr_q      <= rr_ptr_d;
            data_q        <= data_d;
            rom_counter_q <= rom_counter_d;
            ack_q         <= ack_d;
            row_data_q    <= row_data_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.o_rom_counter = rom_counter_q;
    assign bus.o_ack         = ack_q;
    assign bus.o_row_data    = row_data_q;
    assign bus.o_busy        = busy_q;

    ack_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_q));
    data_only_with_ack_a: assert property (@(posedge clk) disable iff (!rst_n)
        (ack_q == '0) |-> (row_data_q == 8'h00));

endmodule

// File: tb/tb_sprite_rom_sched.sv
// Scoreboard bench for sprite_rom_sched with a combinational 8x8 ROM model.
// Mirror scenario is compiled in when SPRITE_SCHED_MIRROR_EN is defined.
module tb_sprite_rom_sched;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_rom_sched_if #(.NUM_REQ(N)) bus();
    sprite_rom_sched #(.NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] rom [8];
    always_comb bus.i_rom_color = rom[bus.o_rom_counter[5:3]][bus.o_rom_counter[2:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] ack;
        logic [7:0]   data;
        int           cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input logic [N-1:0] ack, input logic [7:0] data, input int c);
        exp_t e;
        e.ack = ack; e.data = data; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_ack != '0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.o_ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b exp 000", bus.o_ack); end
        checks++; if (bus.o_row_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.o_row_data); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.o_busy); end
        checks++; if (bus.o_rom_counter !== 6'd0) begin errors++; $display("FAIL reset_counter got %h exp 00", bus.o_rom_counter); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit seen;
        exp_t e;
        @(posedge clk); #1;
        bus.i_row = '0;
        bus.i_req = 3'b001;
        push_exp(3'b001, 8'h70, cyc + 10);
        @(posedge clk); #1;
        bus.i_req = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_rom_counter !== 6'(c)) begin
                errors++; $display("FAIL single_counter col %0d got %h exp %h", c, bus.o_rom_counter, 6'(c));
            end
            if (c == 3) begin
                checks++;
                if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bus.o_busy); end
            end
        end
        wait_ack(seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            errors++; $display("FAIL single_timeout got no ack exp %b", e.ack);
        end else begin
            checks++; if (bus.o_ack !== e.ack) begin errors++; $display("FAIL single_ack got %b exp %b", bus.o_ack, e.ack); end
            checks++; if (bus.o_row_data !== e.data) begin errors++; $display("FAIL single_data got %h exp %h", bus.o_row_data, e.data); end
            checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL single_latency got cycle %0d exp %0d", cyc, e.cyc); end
        end
        @(negedge clk);
        checks++; if (bus.o_ack !== 3'b000) begin errors++; $display("FAIL single_pulse got %b exp 000", bus.o_ack); end
        checks++; if (bus.o_row_data !== 8'h00) begin errors++; $display("FAIL single_data_clear got %h exp 00", bus.o_row_data); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", bus.o_busy); end
    endtask

    task automatic test_reset_mid_fetch();
        int acks;
        @(posedge clk); #1;
        bus.i_row = {3'd0, 3'd4, 3'd0};
        bus.i_req = 3'b010;
        @(posedge clk); #1;
        bus.i_req = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_rom_counter !== 6'd0) begin errors++; $display("FAIL midrst_counter got %h exp 00", bus.o_rom_counter); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.o_busy); end
        checks++; if (bus.o_ack !== 3'b000) begin errors++; $display("FAIL midrst_ack got %b exp 000", bus.o_ack); end
        @(posedge clk); #1 rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_ack != '0) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL midrst_no_ack got %0d acks exp 0", acks); end
    endtask

    task automatic test_three_simultaneous();
        bit seen;
        exp_t e;
        do_reset();
        @(posedge clk); #1;
        bus.i_row = {3'd5, 3'd4, 3'd3};
        bus.i_req = 3'b111;
        push_exp(3'b001, 8'h39, cyc + 10);
        push_exp(3'b010, 8'h3F, cyc + 20);
        push_exp(3'b100, 8'h1E, cyc + 30);
        for (int k = 0; k < 3; k++) begin
            wait_ack(seen);
            e = exp_q.pop_front();
            checks++;
            if (!seen) begin
                errors++; $display("FAIL three_timeout idx %0d got no ack exp %b", k, e.ack);
            end else begin
                bus.i_req = bus.i_req & ~bus.o_ack;
                checks++; if (bus.o_ack !== e.ack) begin errors++; $display("FAIL three_ack idx %0d got %b exp %b", k, bus.o_ack, e.ack); end
                checks++; if (bus.o_row_data !== e.data) begin errors++; $display("FAIL three_data idx %0d got %h exp %h", k, bus.o_row_data, e.data); end
                checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL three_cycle idx %0d got %0d exp %0d", k, cyc, e.cyc); end
            end
        end
        bus.i_req = '0;
    endtask

    task automatic test_fairness();
        bit seen;
        exp_t e;
        do_reset();
        @(posedge clk); #1;
        bus.i_row = {3'd5, 3'd0, 3'd3};
        bus.i_req = 3'b101;
        push_exp(3'b001, 8'h39, cyc + 10);
        push_exp(3'b100, 8'h1E, cyc + 20);
        push_exp(3'b001, 8'h39, cyc + 30);
        push_exp(3'b100, 8'h1E, cyc + 40);
        for (int k = 0; k < 4; k++) begin
            wait_ack(seen);
            e = exp_q.pop_front();
            if (k == 3) bus.i_req = '0;
            checks++;
            if (!seen) begin
                errors++; $display("FAIL fair_timeout idx %0d got no ack exp %b", k, e.ack);
            end else begin
                checks++; if (bus.o_ack !== e.ack) begin errors++; $display("FAIL fair_ack idx %0d got %b exp %b", k, bus.o_ack, e.ack); end
                checks++; if (bus.o_row_data !== e.data) begin errors++; $display("FAIL fair_data idx %0d got %h exp %h", k, bus.o_row_data, e.data); end
                checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL fair_cycle idx %0d got %0d exp %0d", k, cyc, e.cyc); end
            end
        end
        bus.i_req = '0;
    endtask

    task automatic test_back_to_back();
        bit seen;
        exp_t e;
        logic [2:0] next_row [3];
        next_row[0] = 3'd5; next_row[1] = 3'd0; next_row[2] = 3'd0;
        do_reset();
        @(posedge clk); #1;
        bus.i_row = {3'd0, 3'd4, 3'd0};
        bus.i_req = 3'b010;
        push_exp(3'b010, 8'h3F, cyc + 10);
        push_exp(3'b010, 8'h1E, cyc + 20);
        push_exp(3'b010, 8'h70, cyc + 30);
        for (int k = 0; k < 3; k++) begin
            wait_ack(seen);
            e = exp_q.pop_front();
            bus.i_row = {3'd0, next_row[k], 3'd0};
            if (k == 2) bus.i_req = '0;
            checks++;
            if (!seen) begin
                errors++; $display("FAIL b2b_timeout idx %0d got no ack exp %b", k, e.ack);
            end else begin
                checks++; if (bus.o_ack !== e.ack) begin errors++; $display("FAIL b2b_ack idx %0d got %b exp %b", k, bus.o_ack, e.ack); end
                checks++; if (bus.o_row_data !== e.data) begin errors++; $display("FAIL b2b_data idx %0d got %h exp %h", k, bus.o_row_data, e.data); end
                checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL b2b_cycle idx %0d got %0d exp %0d", k, cyc, e.cyc); end
            end
        end
    endtask

    task automatic test_capture();
        bit seen;
        exp_t e;
        do_reset();
        @(posedge clk); #1;
        bus.i_row = {3'd0, 3'd0, 3'd7};
        bus.i_req = 3'b001;
        push_exp(3'b001, 8'h14, cyc + 10);
        @(posedge clk); #1;
        repeat (2) @(negedge clk);
        bus.i_row = {3'd0, 3'd0, 3'd1};
        bus.i_req = '0;
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_rom_counter[5:3] !== 3'd7) begin
                errors++; $display("FAIL capture_row col %0d got %0d exp 7", c, bus.o_rom_counter[5:3]);
            end
        end
        wait_ack(seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            errors++; $display("FAIL capture_timeout got no ack exp %b", e.ack);
        end else begin
            checks++; if (bus.o_ack !== e.ack) begin errors++; $display("FAIL capture_ack got %b exp %b", bus.o_ack, e.ack); end
            checks++; if (bus.o_row_data !== e.data) begin errors++; $display("FAIL capture_data got %h exp %h", bus.o_row_data, e.data); end
        end
    endtask

`ifdef SPRITE_SCHED_MIRROR_EN
    task automatic test_mirror();
        bit seen;
        exp_t e;
        logic [7:0] want [2];
        want[0] = 8'h9C; want[1] = 8'h39;
        for (int m = 0; m < 2; m++) begin
            do_reset();
            @(posedge clk); #1;
            bus.i_mirror = (m == 0) ? 3'b001 : 3'b000;
            bus.i_row = {3'd0, 3'd0, 3'd3};
            bus.i_req = 3'b001;
            push_exp(3'b001, want[m], cyc + 10);
            @(posedge clk); #1;
            bus.i_req = '0;
            bus.i_mirror = '0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                checks++;
                if (bus.o_rom_counter !== {3'd3, (m == 0) ? 3'(7 - c) : 3'(c)}) begin
                    errors++; $display("FAIL mirror_counter m %0d step %0d got %h", m, c, bus.o_rom_counter);
                end
            end
            wait_ack(seen);
            e = exp_q.pop_front();
            checks++;
            if (!seen) begin
                errors++; $display("FAIL mirror_timeout m %0d got no ack exp %b", m, e.ack);
            end else begin
                checks++; if (bus.o_row_data !== e.data) begin errors++; $display("FAIL mirror_data m %0d got %h exp %h", m, bus.o_row_data, e.data); end
                checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL mirror_cycle m %0d got %0d exp %0d", m, cyc, e.cyc); end
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = 8'h70; rom[1] = 8'hA5; rom[2] = 8'hC3; rom[3] = 8'h39;
        rom[4] = 8'h3F; rom[5] = 8'h1E; rom[6] = 8'h81; rom[7] = 8'h14;
        rst_n = 1'b0;
        bus.i_req = '0;
        bus.i_row = '0;
`ifdef SPRITE_SCHED_MIRROR_EN
        bus.i_mirror = '0;
`endif
        test_reset();
        test_single();
        test_reset_mid_fetch();
        test_three_simultaneous();
        test_fairness();
        test_back_to_back();
        test_capture();
`ifdef SPRITE_SCHED_MIRROR_EN
        test_mirror();
`endif
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
